// File: rtl/switch_command_queue_pkg.sv
// Shared types and field layout for the switch command queue.
// Command word is {op, addr, data}; data carries crosspoint x/y/on.
package switch_command_queue_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int OP_W   = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int CMD_W  = OP_W + ADDR_W + DATA_W;

  localparam int OP_RST = 0;
  localparam int OP_SET = 1;

  localparam int D_X_LSB  = 0;
  localparam int D_X_W    = 4;
  localparam int D_Y_LSB  = 4;
  localparam int D_Y_W    = 2;
  localparam int D_ON_BIT = 8;

endpackage

// File: rtl/switch_command_queue_fifo.sv
// Command FIFO: binary wrap pointers, occupancy counter, sync flush.
// Flush beats both push and pop in the same cycle.
module switch_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 28
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             we;
  logic             re;

  always_comb begin
    full  = (level == LW'(DEPTH));
    we    = push && !full && !flush;
    re    = pop && (level != '0) && !flush;
    rdata = mem[rptr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + AW'(we);
      rptr  <= rptr + AW'(re);
      level <= level + LW'(we) - LW'(re);
    end
  end

endmodule

// File: rtl/switch_command_queue.sv
// Queues host commands and issues them one at a time to a switch group,
// pacing on the group's rdy handshake with ack/done watchdogs.
module switch_command_queue
  import switch_command_queue_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int ACK_TIMEOUT  = 8,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [OP_W-1:0]        cmd_op,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  input  logic                   flush,
  output logic                   cs,
  output logic [OP_W-1:0]        op,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      data_in,
  input  logic                   rdy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   err
);

  localparam int TMAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT
                                                      : DONE_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  state_t         state;
  state_t         state_n;
  logic [TW-1:0]  timer;
  logic           pop;
  logic           timer_clr;
  logic           err_set;
  logic           full;
  logic [CMD_W-1:0] head;

  switch_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (cmd_valid),
    .wdata ({cmd_op, cmd_addr, cmd_data}),
    .pop   (pop),
    .rdata (head),
    .level (level),
    .full  (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    timer_clr = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      IDLE: begin
        if ((level != '0) && rdy && !flush) begin
          state_n = ISSUE;
          pop     = 1'b1;
        end
      end
      ISSUE: begin
        state_n   = WAIT_ACK;
        timer_clr = 1'b1;
      end
      WAIT_ACK: begin
        if (!rdy) begin
          state_n   = WAIT_DONE;
          timer_clr = 1'b1;
        end else if (timer == TW'(ACK_TIMEOUT)) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      WAIT_DONE: begin
        if (rdy) begin
          state_n = IDLE;
        end else if (timer == TW'(DONE_TIMEOUT)) begin
          err_set = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Issued fields latch on the pop so they hold between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      err     <= 1'b0;
      op      <= '0;
      addr    <= '0;
      data_in <= '0;
    end else begin
      if (timer_clr)
        timer <= '0;
      else if (state == WAIT_ACK || state == WAIT_DONE)
        timer <= timer + TW'(1);
      if (err_set) err <= 1'b1;
      if (pop) {op, addr, data_in} <= head;
    end
  end

  always_comb begin
    cs        = (state == ISSUE);
    busy      = (state != IDLE) || (level != '0);
    cmd_ready = !full;
  end

endmodule

// File: tb/tb_switch_command_queue.sv
// Directed bench with a queue-based scoreboard and a downstream rdy model.
module tb_switch_command_queue;
  import switch_command_queue_pkg::*;

  localparam int DEPTH        = 8;
  localparam int ACK_TIMEOUT  = 8;
  localparam int DONE_TIMEOUT = 64;

  typedef enum int {M_NORMAL, M_HOLD0, M_STUCK1, M_STUCK0} mode_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        flush;
  logic        cs;
  logic [3:0]  op;
  logic [7:0]  addr;
  logic [15:0] data_in;
  logic        rdy;
  logic [3:0]  level;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cs_count = 0;
  mode_t mode = M_NORMAL;
  int ack_dly = 3;
  int done_dly = 15;

  logic [27:0] mq[$];
  logic [27:0] last_issued = '0;
  bit prev_cs = 0;

  switch_command_queue #(
    .DEPTH        (DEPTH),
    .ACK_TIMEOUT  (ACK_TIMEOUT),
    .DONE_TIMEOUT (DONE_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .flush     (flush),
    .cs        (cs),
    .op        (op),
    .addr      (addr),
    .data_in   (data_in),
    .rdy       (rdy),
    .level     (level),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] xyon(input int x, input int y,
                                       input bit on);
    logic [15:0] d;
    d = '0;
    d[3:0] = 4'(x);
    d[5:4] = 2'(y);
    d[8]   = on;
    return d;
  endfunction

  // Model: host-side acceptance into an unbounded-then-capped queue.
  always @(posedge clk) begin
    if (rst || flush) mq.delete();
    else if (cmd_valid && mq.size() < DEPTH)
      mq.push_back({cmd_op, cmd_addr, cmd_data});
  end

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      prev_cs = 0;
      last_issued = '0;
    end else begin
      if (cs) begin
        cs_count++;
        chk("cs_back_to_back", 32'(prev_cs), 0);
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL cs_unexpected: got cs=1 expected empty queue idle");
        end else begin
          last_issued = mq.pop_front();
        end
      end
      chk("issued_fields", {4'd0, op, addr, data_in}, {4'd0, last_issued});
      chk("level", 32'(level), 32'(mq.size()));
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() != DEPTH));
      prev_cs = cs;
    end
  end

  // Downstream switch group.
  initial begin
    rdy = 1;
    forever begin
      @(negedge clk);
      case (mode)
        M_HOLD0:  rdy = 0;
        M_STUCK1: rdy = 1;
        default: begin
          if (cs && !rst) begin
            repeat (ack_dly) @(negedge clk);
            rdy = 0;
            if (mode == M_NORMAL) begin
              repeat (done_dly) @(negedge clk);
              rdy = 1;
            end
          end else if (mode == M_NORMAL) begin
            rdy = 1;
          end
        end
      endcase
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [3:0] o, input logic [7:0] a,
                      input logic [15:0] d);
    cmd_valid = 1;
    cmd_op    = o;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  task automatic wait_cs(input int maxc, output int n);
    n = 0;
    while (!cs && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_err(input int maxc, output int n);
    n = 0;
    while (!err && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy && n < maxc) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int c0;

  initial begin
    rst = 1;
    cmd_valid = 0;
    cmd_op = '0;
    cmd_addr = '0;
    cmd_data = '0;
    flush = 0;
    do_reset();

    // Reset state
    chk("rst_level", 32'(level), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cs", 32'(cs), 0);
    chk("rst_fields", {4'd0, op, addr, data_in}, 0);
    chk("rst_err", 32'(err), 0);

    // Single switch-array reset command
    c0 = cs_count;
    push(4'(1 << OP_RST), 8'h00, 16'h0000);
    wait_cs(20, n);
    chk("t1_push_to_cs", 32'(n), 1);
    chk("t1_op", 32'(op), 1);
    repeat (40) @(negedge clk);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_err", 32'(err), 0);
    chk("t1_cs_count", 32'(cs_count - c0), 1);

    // Fill FIFO while group is held busy, then drain in order
    mode = M_HOLD0;
    repeat (2) @(negedge clk);
    c0 = cs_count;
    for (int i = 0; i < 8; i++)
      push(4'(1 << OP_SET), 8'(i), xyon(i, i % 4, 1));
    chk("t2_level_full", 32'(level), 8);
    chk("t2_cmd_ready", 32'(cmd_ready), 0);
    push(4'(1 << OP_SET), 8'hff, 16'hffff);
    chk("t2_level_after_drop", 32'(level), 8);
    chk("t2_no_cs", 32'(cs_count - c0), 0);
    mode = M_NORMAL;
    wait_idle(600, n);
    chk("t2_drain_bound", 32'(n < 600), 1);
    chk("t2_cs_count", 32'(cs_count - c0), 8);
    chk("t2_last_addr", 32'(addr), 7);
    chk("t2_last_data", 32'(data_in), 32'h0137);
    chk("t2_level_end", 32'(level), 0);

    // Ack timeout, then queued op=0 command still issues
    mode = M_STUCK1;
    @(negedge clk);
    c0 = cs_count;
    push(4'h0, 8'h21, 16'h0005);
    push(4'(1 << OP_SET), 8'h22, xyon(3, 2, 0));
    wait_cs(20, n);
    chk("t3_cs_found", 32'(n < 20), 1);
    chk("t3_op_zero", 32'(op), 0);
    wait_err(40, n);
    chk("t3_err_latency", 32'(n), ACK_TIMEOUT + 2);
    wait_cs(20, n);
    chk("t3_next_cs_found", 32'(n < 20), 1);
    chk("t3_next_addr", 32'(addr), 32'h22);
    wait_idle(100, n);
    chk("t3_cs_count", 32'(cs_count - c0), 2);
    chk("t3_err_sticky", 32'(err), 1);

    mode = M_STUCK0;
    ack_dly = 3;
    do_reset();
    chk("t4_err_cleared", 32'(err), 0);

    // Done timeout, then wait for rdy before issuing again
    c0 = cs_count;
    push(4'(1 << OP_SET), 8'h40, xyon(1, 1, 1));
    wait_cs(20, n);
    wait_err(120, n);
    chk("t4_err_latency", 32'(n), 3 + DONE_TIMEOUT + 2);
    @(negedge clk);
    chk("t4_idle_after_timeout", 32'(busy), 0);
    push(4'(1 << OP_SET), 8'h41, xyon(2, 0, 1));
    repeat (20) @(negedge clk);
    chk("t4_held_by_rdy", 32'(cs_count - c0), 1);
    chk("t4_level_held", 32'(level), 1);
    mode = M_NORMAL;
    wait_idle(100, n);
    chk("t4_cs_count", 32'(cs_count - c0), 2);

    // Flush with a simultaneous push while one command is in flight
    do_reset();
    done_dly = 30;
    c0 = cs_count;
    for (int i = 0; i < 6; i++)
      push(4'(1 << OP_SET), 8'(8'h50 + i), xyon(i, 1, 1));
    chk("t5_level5", 32'(level), 5);
    flush = 1;
    cmd_valid = 1;
    cmd_op = 4'(1 << OP_SET);
    cmd_addr = 8'h5f;
    cmd_data = 16'h0100;
    @(negedge clk);
    flush = 0;
    cmd_valid = 0;
    chk("t5_level_flushed", 32'(level), 0);
    chk("t5_busy_inflight", 32'(busy), 1);
    wait_idle(100, n);
    chk("t5_inflight_done", 32'(n < 100), 1);
    repeat (10) @(negedge clk);
    chk("t5_cs_count", 32'(cs_count - c0), 1);
    chk("t5_err", 32'(err), 0);

    // Asynchronous reset during WAIT_DONE
    c0 = cs_count;
    push(4'(1 << OP_SET), 8'h60, xyon(4, 3, 1));
    push(4'(1 << OP_SET), 8'h61, xyon(5, 3, 1));
    wait_cs(20, n);
    repeat (6) @(negedge clk);
    #1 rst = 1;
    #1;
    chk("t6_cs", 32'(cs), 0);
    chk("t6_fields", {4'd0, op, addr, data_in}, 0);
    chk("t6_level", 32'(level), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err), 0);
    chk("t6_cmd_ready", 32'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (50) @(negedge clk);
    chk("t6_no_cs_after", 32'(cs_count - c0), 1);
    chk("t6_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
